// File: rtl/c3aibadapt_avmm_rdfifo_ctrl.sv
// AVMM read-return FIFO sequencer: pops BEATS narrow entries, assembles one wide readdata word,
// and tracks outstanding commands. Optional idle timeout enabled by C3AIBADAPT_AVMM_RDFIFO_TMO_EN.
module c3aibadapt_avmm_rdfifo_ctrl #(
    parameter int unsigned DWIDTH     = 4,
    parameter int unsigned BEATS      = 8,
    parameter int unsigned MAX_OUTSTD = 4,
    parameter int unsigned CNTW       = 3,
    parameter int unsigned TMO_W      = 10
) (
    input  logic                     rd_clk,
    input  logic                     rd_srst,
    input  logic                     r_ctrl_en,
    input  logic [TMO_W-1:0]         r_timeout,
    input  logic                     cmd_issue,
    output logic                     cmd_ready,
    input  logic                     fifo_rd_empty,
    input  logic [DWIDTH-1:0]        fifo_rd_data,
    output logic                     fifo_rd_en,
    output logic                     fifo_flush,
    output logic [DWIDTH*BEATS-1:0]  avmm_readdata,
    output logic                     avmm_readdatavalid,
    output logic                     avmm_rsp_err,
    output logic [CNTW-1:0]          outstd_cnt
);

    localparam int unsigned RDW       = DWIDTH * BEATS;
    localparam int unsigned BCW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BCW-1:0]  LAST_BEAT = BCW'(BEATS - 1);
    localparam logic [CNTW-1:0] MAX_CNT   = CNTW'(MAX_OUTSTD);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DELIVER = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [BCW-1:0]  beat_q;
    logic [RDW-1:0]  asm_q;
    logic [RDW-1:0]  asm_c;
    logic [CNTW-1:0] outstd_d;
    logic            pop_c;
    logic            last_pop_c;
    logic            deliver_c;
    logic            issue_c;
    logic            tmo_hit_c;

`ifdef C3AIBADAPT_AVMM_RDFIFO_TMO_EN
    logic [TMO_W-1:0] idle_q;

    // Timeout fires on the idle cycle that brings the count up to the threshold.
    assign tmo_hit_c = (state_q == ST_COLLECT) && r_ctrl_en && !pop_c &&
                       (r_timeout != '0) && (idle_q >= (r_timeout - TMO_W'(1)));

    always_ff @(posedge rd_clk) begin
        if (rd_srst || (state_q != ST_COLLECT) || pop_c || tmo_hit_c) begin
            idle_q <= '0;
        end else if (r_ctrl_en && (r_timeout != '0) && (idle_q != '1)) begin
            idle_q <= idle_q + TMO_W'(1);
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^r_timeout;
    assign tmo_hit_c  = 1'b0;
`endif

    always_ff @(posedge rd_clk) begin
        if (rd_srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if ((outstd_cnt != '0) && r_ctrl_en) state_d = ST_COLLECT;
            ST_COLLECT: if (last_pop_c || tmo_hit_c)         state_d = ST_DELIVER;
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Pop strobe, beat insertion and outstanding-count arithmetic.
    always_comb begin
        pop_c      = (state_q == ST_COLLECT) && r_ctrl_en && !fifo_rd_empty;
        last_pop_c = pop_c && (beat_q == LAST_BEAT);
        deliver_c  = (state_q == ST_DELIVER);
        issue_c    = cmd_issue && cmd_ready;
        asm_c      = asm_q;
        asm_c[beat_q*DWIDTH +: DWIDTH] = fifo_rd_data;
        outstd_d   = outstd_cnt;
        if (issue_c && !deliver_c) begin
            outstd_d = outstd_cnt + CNTW'(1);
        end else if (!issue_c && deliver_c) begin
            outstd_d = outstd_cnt - CNTW'(1);
        end
    end

    assign fifo_rd_en = pop_c;

    always_ff @(posedge rd_clk) begin
        if (rd_srst) begin
            beat_q             <= '0;
            asm_q              <= '0;
            avmm_readdata      <= '0;
            avmm_readdatavalid <= 1'b0;
            avmm_rsp_err       <= 1'b0;
            fifo_flush         <= 1'b0;
            outstd_cnt         <= '0;
            cmd_ready          <= 1'b0;
        end else begin
            avmm_readdatavalid <= last_pop_c || tmo_hit_c;
            avmm_rsp_err       <= tmo_hit_c;
            fifo_flush         <= tmo_hit_c;
            outstd_cnt         <= outstd_d;
            cmd_ready          <= (outstd_d < MAX_CNT);
            if (tmo_hit_c) begin
                beat_q        <= '0;
                avmm_readdata <= '0;
            end else if (pop_c) begin
                asm_q <= asm_c;
                if (last_pop_c) begin
                    beat_q        <= '0;
                    avmm_readdata <= asm_c;
                end else begin
                    beat_q <= beat_q + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_c3aibadapt_avmm_rdfifo_ctrl.sv
// Self-checking bench for c3aibadapt_avmm_rdfifo_ctrl: queue-based FIFO and word-level reference model.
// Timeout scenarios run when C3AIBADAPT_AVMM_RDFIFO_TMO_EN is defined.
module tb_c3aibadapt_avmm_rdfifo_ctrl;

    localparam int DW    = 4;
    localparam int BEATS = 8;
    localparam int MAXO  = 4;
    localparam int CNTW  = 3;
    localparam int TMOW  = 10;
    localparam int RDW   = DW * BEATS;

    logic            rd_clk = 1'b0;
    logic            rd_srst = 1'b1;
    logic            r_ctrl_en = 1'b0;
    logic [TMOW-1:0] r_timeout = '0;
    logic            cmd_issue = 1'b0;
    logic            cmd_ready;
    logic            fifo_rd_empty = 1'b1;
    logic [DW-1:0]   fifo_rd_data = '0;
    logic            fifo_rd_en;
    logic            fifo_flush;
    logic [RDW-1:0]  avmm_readdata;
    logic            avmm_readdatavalid;
    logic            avmm_rsp_err;
    logic [CNTW-1:0] outstd_cnt;

    always #5 rd_clk = ~rd_clk;

    c3aibadapt_avmm_rdfifo_ctrl #(
        .DWIDTH(DW), .BEATS(BEATS), .MAX_OUTSTD(MAXO), .CNTW(CNTW), .TMO_W(TMOW)
    ) dut (
        .rd_clk(rd_clk), .rd_srst(rd_srst), .r_ctrl_en(r_ctrl_en), .r_timeout(r_timeout),
        .cmd_issue(cmd_issue), .cmd_ready(cmd_ready), .fifo_rd_empty(fifo_rd_empty),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en), .fifo_flush(fifo_flush),
        .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
        .avmm_rsp_err(avmm_rsp_err), .outstd_cnt(outstd_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Bench-side FIFO contents; head is presented on fifo_rd_data.
    logic [DW-1:0] fifo_q[$];

    // Reference model: 0 waiting, 1 collecting beats, 2 delivering.
    int             m_phase = 0;
    logic [DW-1:0]  m_beats[$];
    int             m_idle = 0;
    int             m_out = 0;
    bit             m_ready = 0;
    bit             m_valid = 0;
    bit             m_err = 0;
    bit             m_flush = 0;
    logic [RDW-1:0] m_rdata = '0;

    bit             auto_fill = 0;
    int             pops_word = 0;
    int             pops_total = 0;
    int             deliveries = 0;
    logic [RDW-1:0] last_word = '0;
    bit             last_err = 0;
    bit             last_flush = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit srst, input bit en, input bit issue, input bit pop,
                              input logic [DW-1:0] data);
        int old_out;
        old_out = m_out;
        if (srst) begin
            m_phase = 0; m_beats.delete(); m_idle = 0; m_out = 0; m_ready = 0;
            m_valid = 0; m_err = 0; m_flush = 0; m_rdata = '0;
            return;
        end
        m_valid = 0; m_err = 0; m_flush = 0;
        if (issue && m_ready) m_out++;
        if (m_phase == 2) m_out--;
        m_ready = (m_out < MAXO);
        case (m_phase)
            0: if (old_out != 0 && en) m_phase = 1;
            1: begin
                if (pop) begin
                    m_beats.push_back(data);
                    m_idle = 0;
                    if (m_beats.size() == BEATS) begin
                        for (int k = 0; k < BEATS; k++) m_rdata[k*DW +: DW] = m_beats[k];
                        m_valid = 1;
                        m_phase = 2;
                        m_beats.delete();
                    end
                end
`ifdef C3AIBADAPT_AVMM_RDFIFO_TMO_EN
                else if (en && r_timeout != 0) begin
                    if (m_idle < (1 << TMOW) - 1) m_idle++;
                    if (m_idle >= int'(r_timeout)) begin
                        m_rdata = '0; m_valid = 1; m_err = 1; m_flush = 1;
                        m_phase = 2; m_beats.delete(); m_idle = 0;
                    end
                end
`endif
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: drive inputs, check the pop strobe, advance model and FIFO, check registered outputs.
    task automatic step(input bit srst, input bit en, input bit issue, input bit gap);
        bit exp_en;
        bit accepted;
        rd_srst = srst; r_ctrl_en = en; cmd_issue = issue;
        fifo_rd_empty = gap || (fifo_q.size() == 0);
        fifo_rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        #1;
        exp_en = (m_phase == 1) && en && !fifo_rd_empty;
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_en));
        @(posedge rd_clk);
        accepted = issue && m_ready && !srst;
        model_edge(srst, en, issue, exp_en, fifo_rd_data);
        if (fifo_rd_en && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (exp_en) begin pops_word++; pops_total++; end
        if (srst) pops_word = 0;
        if (srst || m_flush) fifo_q.delete();
        if (accepted && auto_fill)
            for (int k = 0; k < BEATS; k++) fifo_q.push_back(DW'($urandom));
        @(negedge rd_clk);
        chk("readdata", avmm_readdata, m_rdata);
        chk("readdatavalid", 32'(avmm_readdatavalid), 32'(m_valid));
        chk("rsp_err", 32'(avmm_rsp_err), 32'(m_err));
        chk("fifo_flush", 32'(fifo_flush), 32'(m_flush));
        chk("outstd_cnt", 32'(outstd_cnt), 32'(m_out));
        chk("cmd_ready", 32'(cmd_ready), 32'(m_ready));
        if (avmm_readdatavalid) begin
            deliveries++;
            last_word = avmm_readdata;
            last_err = avmm_rsp_err;
            last_flush = fifo_flush;
            pops_word = 0;
        end
    endtask

    task automatic push_ramp();
        for (int k = 0; k < BEATS; k++) fifo_q.push_back(DW'(k));
    endtask

    task automatic run_until_delivery(input string name, input int budget);
        int d0;
        int n;
        d0 = deliveries;
        n = 0;
        while (deliveries == d0 && n < budget) begin
            step(0, 1, 0, 0);
            n++;
        end
        checks++;
        if (deliveries == d0) begin
            errors++;
            $display("FAIL %s: no delivery within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int p0;
        int d0;
        int n;
        int gapn;
        r_timeout = 10'd16;
        @(negedge rd_clk);

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_outstd", 32'(outstd_cnt), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rdata", avmm_readdata, 32'd0);
        chk("rst_valid", 32'(avmm_readdatavalid), 32'd0);
        step(0, 1, 0, 0);
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Normal word
        push_ramp();
        p0 = pops_total;
        step(0, 1, 1, 0);
        chk("issue_cnt", 32'(outstd_cnt), 32'd1);
        run_until_delivery("normal", 40);
        chk("normal_word", last_word, 32'h76543210);
        chk("normal_err", 32'(last_err), 32'd0);
        chk("normal_pops", 32'(pops_total - p0), 32'd8);
        step(0, 1, 0, 0);
        chk("normal_cnt", 32'(outstd_cnt), 32'd0);

        // Empty gap of 5 cycles after beat 3
        push_ramp();
        step(0, 1, 1, 0);
        d0 = deliveries;
        gapn = 0;
        n = 0;
        while (deliveries == d0 && n < 60) begin
            if (pops_word == 4 && gapn < 5) begin
                gapn++;
                step(0, 1, 0, 1);
            end else begin
                step(0, 1, 0, 0);
            end
            n++;
        end
        chk("gap_delivered", 32'(deliveries - d0), 32'd1);
        chk("gap_word", last_word, 32'h76543210);
        chk("gap_len", 32'(gapn), 32'd5);
        step(0, 1, 0, 0);

        // Back-pressure at MAX_OUTSTD
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        chk("bp_cnt", 32'(outstd_cnt), 32'd4);
        chk("bp_ready", 32'(cmd_ready), 32'd0);
        push_ramp();
        run_until_delivery("bp", 40);
        step(0, 1, 0, 0);
        chk("bp_cnt_after", 32'(outstd_cnt), 32'd3);
        chk("bp_ready_after", 32'(cmd_ready), 32'd1);

        // Issue in the delivery cycle
        push_ramp();
        run_until_delivery("simul", 40);
        step(0, 1, 1, 0);
        chk("simul_cnt", 32'(outstd_cnt), 32'd3);

        // Drain the remaining commands
        push_ramp(); push_ramp(); push_ramp();
        n = 0;
        while (outstd_cnt != 0 && n < 200) begin
            step(0, 1, 0, 0);
            n++;
        end
        chk("drain_cnt", 32'(outstd_cnt), 32'd0);

        // Reset after 5 pops drops the word
        push_ramp();
        step(0, 1, 1, 0);
        n = 0;
        while (pops_word < 5 && n < 40) begin
            step(0, 1, 0, 0);
            n++;
        end
        d0 = deliveries;
        step(1, 1, 0, 0);
        chk("midrst_cnt", 32'(outstd_cnt), 32'd0);
        chk("midrst_valid", 32'(avmm_readdatavalid), 32'd0);
        chk("midrst_rdata", avmm_readdata, 32'd0);
        step(0, 1, 0, 0);
        chk("midrst_no_delivery", 32'(deliveries - d0), 32'd0);
        push_ramp();
        step(0, 1, 1, 0);
        run_until_delivery("after_rst", 40);
        chk("after_rst_word", last_word, 32'h76543210);
        step(0, 1, 0, 0);

`ifdef C3AIBADAPT_AVMM_RDFIFO_TMO_EN
        // Timeout after 2 beats with threshold 16
        fifo_q.push_back(4'h1);
        fifo_q.push_back(4'h2);
        step(0, 1, 1, 0);
        n = 0;
        while (pops_word < 2 && n < 20) begin
            step(0, 1, 0, 0);
            n++;
        end
        d0 = deliveries;
        n = 0;
        while (deliveries == d0 && n < 40) begin
            step(0, 1, 0, 0);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd16);
        chk("tmo_err", 32'(last_err), 32'd1);
        chk("tmo_flush", 32'(last_flush), 32'd1);
        chk("tmo_word", last_word, 32'd0);
        step(0, 1, 0, 0);
        chk("tmo_cnt", 32'(outstd_cnt), 32'd0);
`endif

        // Randomized traffic
        auto_fill = 1;
        for (int i = 0; i < 3000; i++) begin
`ifdef C3AIBADAPT_AVMM_RDFIFO_TMO_EN
            if ($urandom_range(0, 49) == 0)
                r_timeout = ($urandom_range(0, 2) == 0) ? '0 : TMOW'($urandom_range(4, 40));
`else
            r_timeout = TMOW'($urandom);
`endif
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        checks++;
        if (deliveries < 20) begin
            errors++;
            $display("FAIL random_deliveries: got %0d expected at least 20", deliveries);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
